// File: rtl/scan_ctrl_if.sv
// rtl/scan_ctrl_if.sv - display-side signal bundle for the seven-segment scan controller
interface scan_ctrl_if;
    logic        EN;
    logic [7:0]  MASK;
    logic [31:0] DIGITS;
    logic [2:0]  SEL;
    logic [3:0]  HEX;
    logic        DISP_ON;
    logic        FRAME;

    // Value-register side: drives enable, mask and digits, observes the scan outputs.
    modport master (
        output EN, MASK, DIGITS,
        input  SEL, HEX, DISP_ON, FRAME
    );

    // Scan controller side.
    modport slave (
        input  EN, MASK, DIGITS,
        output SEL, HEX, DISP_ON, FRAME
    );
endinterface

// File: rtl/scan_ctrl.sv
// rtl/scan_ctrl.sv - time-multiplexed 8-digit seven-segment scan controller
module scan_ctrl #(
    parameter int DIV   = 4,
    parameter int BLANK = 1
) (
    input  logic        CP,
    input  logic        RST,
    scan_ctrl_if.slave  bus
);
    localparam int KW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, BLNK, SHOW} state_t;

    state_t        state_q, state_n;
    logic [KW-1:0] k_q, k_n;
    logic [2:0]    sel_q, sel_n;
    logic [3:0]    hex_q, hex_n;
    logic          disp_q, disp_n;
    logic          frame_q, frame_n;

    logic [2:0]    nxt_idx;
    logic [2:0]    low_idx;
    logic [2:0]    start_idx;
    logic          start_slot;
    int            k_inc;

    // First set bit of m searching upward from start, wrapping 7 -> 0.
    function automatic logic [2:0] first_set(input logic [7:0] m, input logic [2:0] start);
        logic [2:0] idx;
        logic [2:0] res;
        logic       found;
        res   = start;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = start + 3'(i);
            if (!found && m[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign nxt_idx = first_set(bus.MASK, sel_q + 3'd1);
    assign low_idx = first_set(bus.MASK, 3'd0);
    assign k_inc   = int'(k_q) + 1;

    // Next-state and next-output logic; a new slot loads SEL/HEX and restarts blanking.
    always_comb begin
        state_n    = state_q;
        k_n        = k_q;
        sel_n      = sel_q;
        hex_n      = hex_q;
        disp_n     = 1'b0;
        frame_n    = 1'b0;
        start_slot = 1'b0;
        start_idx  = low_idx;

        if (!bus.EN) begin
            state_n = IDLE;
            k_n     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.MASK != 8'h00) begin
                        start_slot = 1'b1;
                        start_idx  = low_idx;
                    end
                end
                BLNK, SHOW: begin
                    if (k_inc == DIV) begin
                        if (bus.MASK == 8'h00) begin
                            state_n = IDLE;
                            k_n     = '0;
                        end else begin
                            start_slot = 1'b1;
                            start_idx  = nxt_idx;
                        end
                    end else begin
                        k_n     = k_q + KW'(1);
                        disp_n  = (k_inc >= BLANK);
                        state_n = (k_inc >= BLANK) ? SHOW : BLNK;
                        // Wrap flag is registered on entry to the slot's last cycle.
                        frame_n = (k_inc == DIV - 1) && (bus.MASK != 8'h00) && (nxt_idx <= sel_q);
                    end
                end
                default: begin
                    state_n = IDLE;
                    k_n     = '0;
                end
            endcase
        end

        if (start_slot) begin
            sel_n   = start_idx;
            hex_n   = bus.DIGITS[{start_idx, 2'b00} +: 4];
            k_n     = '0;
            state_n = (BLANK > 0) ? BLNK : SHOW;
            disp_n  = (BLANK == 0);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CP) begin
        if (RST) begin
            state_q <= IDLE;
            k_q     <= '0;
            sel_q   <= 3'd0;
            hex_q   <= 4'd0;
            disp_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_n;
            k_q     <= k_n;
            sel_q   <= sel_n;
            hex_q   <= hex_n;
            disp_q  <= disp_n;
            frame_q <= frame_n;
        end
    end

    assign bus.SEL     = sel_q;
    assign bus.HEX     = hex_q;
    assign bus.DISP_ON = disp_q;
    assign bus.FRAME   = frame_q;
endmodule

// File: tb/tb_scan_ctrl.sv
// tb/tb_scan_ctrl.sv - self-checking bench for scan_ctrl
module tb_scan_ctrl;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    scan_ctrl_if a ();
    scan_ctrl_if b ();

    scan_ctrl #(.DIV(4), .BLANK(1)) u_main (.CP(clk), .RST(rst), .bus(a.slave));
    scan_ctrl #(.DIV(2), .BLANK(0)) u_fast (.CP(clk), .RST(rst), .bus(b.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [7:0]  mask;
        logic [31:0] digits;
        logic [2:0]  sel;
        logic [3:0]  hex;
        logic        disp;
        logic        frame;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] D0 = 32'h7654_3210;

    task automatic add(input logic r, input logic e, input logic [7:0] m, input logic [31:0] d,
                       input logic [2:0] s, input logic [3:0] h, input logic dp, input logic fr);
        vec_t v;
        v.rst = r; v.en = e; v.mask = m; v.digits = d;
        v.sel = s; v.hex = h; v.disp = dp; v.frame = fr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string name, input int idx, input logic [2:0] s, input logic [3:0] h,
                           input logic dp, input logic fr);
        check({name, ".sel"},   idx, 32'(a.SEL),     32'(s));
        check({name, ".hex"},   idx, 32'(a.HEX),     32'(h));
        check({name, ".disp"},  idx, 32'(a.DISP_ON), 32'(dp));
        check({name, ".frame"}, idx, 32'(a.FRAME),   32'(fr));
    endtask

    initial begin
        logic [2:0] s;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        a.EN = 1'b0; a.MASK = 8'h00; a.DIGITS = 32'h0;
        b.EN = 1'b0; b.MASK = 8'h00; b.DIGITS = 32'h0;

        // Reset, then basic full scan (40 cycles covers a wrap and a second frame start).
        add(1, 0, 8'h00, D0, 3'd0, 4'd0, 1'b0, 1'b0);
        for (int c = 0; c < 40; c++) begin
            s = 3'((c / 4) % 8);
            add(0, 1, 8'hFF, D0, s, {1'b0, s}, (c % 4) != 0, (c % 32) == 31);
        end
        // Skip and wrap: digits 0,2,7, 12-cycle frame.
        add(1, 0, 8'h00, D0, 3'd0, 4'd0, 1'b0, 1'b0);
        for (int c = 0; c < 24; c++) begin
            case ((c / 4) % 3)
                0:       s = 3'd0;
                1:       s = 3'd2;
                default: s = 3'd7;
            endcase
            add(0, 1, 8'h85, D0, s, {1'b0, s}, (c % 4) != 0, (c % 12) == 11);
        end
        // Single digit, then mask emptied mid-slot.
        add(1, 0, 8'h00, D0, 3'd0, 4'd0, 1'b0, 1'b0);
        for (int c = 0; c < 13; c++)
            add(0, 1, 8'h10, D0, 3'd4, 4'd4, (c % 4) != 0, (c % 4) == 3);
        add(0, 1, 8'h00, D0, 3'd4, 4'd4, 1'b1, 1'b0);
        add(0, 1, 8'h00, D0, 3'd4, 4'd4, 1'b1, 1'b0);
        add(0, 1, 8'h00, D0, 3'd4, 4'd4, 1'b1, 1'b0);
        add(0, 1, 8'h00, D0, 3'd4, 4'd4, 1'b0, 1'b0);
        add(0, 1, 8'h00, D0, 3'd4, 4'd4, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; a.EN = vecs[i].en; a.MASK = vecs[i].mask; a.DIGITS = vecs[i].digits;
            tick();
            check_a("tbl", i, vecs[i].sel, vecs[i].hex, vecs[i].disp, vecs[i].frame);
        end

        // Mid-slot DIGITS and MASK changes during the SEL=3 slot.
        rst = 1'b1; a.EN = 1'b0; tick();
        rst = 1'b0; a.EN = 1'b1; a.MASK = 8'hFF; a.DIGITS = D0;
        for (int c = 0; c <= 12; c++) tick();
        check_a("mid_start", 12, 3'd3, 4'd3, 1'b0, 1'b0);
        a.DIGITS = 32'hFFFF_FFFF; a.MASK = 8'hF7;
        for (int c = 13; c <= 15; c++) begin
            tick();
            check_a("mid_hold", c, 3'd3, 4'd3, 1'b1, 1'b0);
        end
        tick();
        check_a("mid_next", 16, 3'd4, 4'hF, 1'b0, 1'b0);

        // EN drop during a SHOW cycle of SEL=5, then resume from lowest bit.
        rst = 1'b1; a.EN = 1'b0; tick();
        rst = 1'b0; a.EN = 1'b1; a.MASK = 8'hFF; a.DIGITS = D0;
        for (int c = 0; c <= 21; c++) tick();
        check_a("en_show", 21, 3'd5, 4'd5, 1'b1, 1'b0);
        a.EN = 1'b0;
        tick();
        check_a("en_drop", 0, 3'd5, 4'd5, 1'b0, 1'b0);
        tick();
        check_a("en_idle", 0, 3'd5, 4'd5, 1'b0, 1'b0);
        a.EN = 1'b1;
        tick();
        check_a("en_resume", 0, 3'd0, 4'd0, 1'b0, 1'b0);
        tick();
        check_a("en_resume", 1, 3'd0, 4'd0, 1'b1, 1'b0);

        // Reset during SEL=6.
        a.DIGITS = 32'h1234_5678;
        rst = 1'b1; tick();
        rst = 1'b0; a.DIGITS = D0;
        for (int c = 0; c <= 25; c++) tick();
        check_a("rst_pre", 25, 3'd6, 4'd6, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        check_a("rst_mid", 0, 3'd0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0; a.EN = 1'b0;

        // BLANK=0, DIV=2: display stays on while SEL steps every two cycles.
        rst = 1'b1; tick();
        check("fast_rst.disp", 0, 32'(b.DISP_ON), 32'd0);
        rst = 1'b0; b.EN = 1'b1; b.MASK = 8'hFF; b.DIGITS = D0;
        for (int c = 0; c < 18; c++) begin
            tick();
            s = 3'((c / 2) % 8);
            check("fast.sel",   c, 32'(b.SEL),     32'(s));
            check("fast.hex",   c, 32'(b.HEX),     32'(s));
            check("fast.disp",  c, 32'(b.DISP_ON), 32'd1);
            check("fast.frame", c, 32'(b.FRAME),   32'((c % 16) == 15));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/scan_ctrl.md
# scan_ctrl

Time-multiplexed scan controller for the 8-digit seven-segment display. It sequences the 3-bit select into the 3-to-8 digit decoder and presents the matching hex nibble to the segment decoder. Disabled digits are skipped, and a blanking interval is inserted at the start of every digit slot to suppress ghosting. It sits between the 32-bit display value register and the digit/segment decoders, on the single system clock.

## Interface
- DIV, default 4: cycles per digit slot. Legal range DIV ≥ 2.
- BLANK, default 1: blanking cycles at the start of each slot. Legal range 0 ≤ BLANK < DIV.

Ports:
- CP, input, 1: system clock. All logic is on the rising edge.
- RST, input, 1: synchronous, active-high reset.
- EN, input, 1: scan enable.
- MASK, input, 8: digit enable. Bit i enables digit i.
- DIGITS, input, 32: display value. Digit i is DIGITS[4i+3:4i].
- SEL, output, 3: digit index to the 3-to-8 decoder. Registered.
- HEX, output, 4: nibble of the selected digit. Registered.
- DISP_ON, output, 1: decoder/segment enable. Registered. High only in the display part of a slot.
- FRAME, output, 1: one-cycle pulse on the last cycle of a slot whose successor wraps around.

## Operation
- **Registers:** state ∈ {IDLE, BLNK, SHOW}, slot counter k (0..DIV-1), SEL, HEX, DISP_ON, FRAME.
- **Reset:** RST=1 at an edge forces state=IDLE, k=0, SEL=0, HEX=0, DISP_ON=0, FRAME=0. Reset overrides every other input, including mid-slot.
- **IDLE:**
  - DISP_ON=0. SEL and HEX hold.
  - When EN=1 and MASK≠0, the next edge starts a slot at the lowest set bit of MASK.
- **Slot start (edge entering k=0):**
  - SEL ← new index n.
  - HEX ← DIGITS nibble n, sampled at this edge. DIGITS changes mid-slot are not visible until the next slot.
  - state ← BLNK if BLANK>0, else SHOW.
- **Within a slot:**
  - During cycle k, DISP_ON = (k ≥ BLANK).
  - BLNK→SHOW happens at the edge where k becomes BLANK.
  - SEL and HEX are stable for the whole slot.
- **Slot end (cycle k=DIV-1):**
  - The next index is the first set bit of MASK, sampled in this cycle, searching upward from SEL+1 mod 8 with wrap-around.
  - FRAME=1 during this cycle iff that next index ≤ SEL. With a single enabled digit, every slot pulses FRAME.
  - If MASK=0 in this cycle, the next state is IDLE and FRAME=0.
- **MASK change mid-slot:** the current slot always completes, even if its own bit is cleared.
- **EN=0 at an edge (any state):**
  - Next state is IDLE, k=0, DISP_ON=0, FRAME=0.
  - SEL and HEX hold.
  - Re-enable restarts from the lowest set bit, not from the held SEL.
- **Width rules:**
  - k uses clog2(DIV) bits.
  - The index search is modulo 8 (3-bit wrap 7→0).

## Timing
- EN rise with MASK≠0 sampled at edge E:
  - At E, SEL/HEX are valid (one-cycle latency from IDLE).
  - DISP_ON rises at edge E+BLANK.
- Slot length is exactly DIV cycles, with no gap between consecutive slots.
- Full frame length is DIV × popcount(MASK) cycles, using MASK at the slot boundaries.
- DISP_ON is low for exactly BLANK cycles around every SEL change, so SEL never changes while DISP_ON=1.
- FRAME is high for exactly one cycle, coincident with DISP_ON=1 when BLANK<DIV.
- Clearing EN takes effect at the next edge: DISP_ON=0 one cycle after EN is sampled low.

## Test plan
- **Basic scan:** reset; DIV=4, BLANK=1, MASK=8'hFF, DIGITS=32'h76543210, EN=1.
  - SEL steps 0..7 every 4 cycles, with HEX=SEL.
  - DISP_ON pattern 0,1,1,1 per slot.
  - FRAME pulses once every 32 cycles, on the last cycle of SEL=7.
- **Skip and wrap:** MASK=8'b1000_0101.
  - SEL sequence 0,2,7,0,…
  - FRAME is high on the last cycle of the SEL=7 slot.
  - Frame is 12 cycles.
- **Single digit and empty mask:**
  - MASK=8'h10: SEL=4 continuously; FRAME every 4 cycles; DISP_ON low one cycle per slot.
  - Then MASK=0 mid-slot: the slot completes, state goes IDLE, DISP_ON stays 0, and SEL/HEX hold 4.
- **Mid-slot changes:**
  - DIGITS changed during a SEL=3 slot: HEX stays constant until the next slot.
  - Bit 3 of MASK cleared during that slot: the slot still lasts 4 cycles, then SEL advances.
- **EN drop and resume:**
  - EN=0 during a SHOW cycle of SEL=5: the next cycle has DISP_ON=0, FRAME=0, SEL=5 held.
  - EN=1 again with MASK=8'hFF: SEL=0 one cycle later.
- **Reset mid-operation / BLANK=0:**
  - RST=1 during SEL=6: the next cycle has SEL=0, HEX=0, DISP_ON=0, FRAME=0.
  - With BLANK=0, DIV=2: DISP_ON stays 1 continuously while SEL steps every 2 cycles.
